mac_matrix_driver: RTL and testbench

Sequencer that drives one mac8bc2 dot-product unit to compute a full 5x5 signed int8 matrix product C = A x B.
- Latches A and B on start.
- For each of the 25 elements it presents row i of A and column j of B to the MAC, runs the MAC handshake and captures the 8-bit result into the C buffer.
- Sits between the HPS-facing register/bridge logic and the MAC datapath.

---
 rtl/mac_matrix_driver.sv | 205 ++++++++++++++++++++
 tb/tb_mac_matrix_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_matrix_driver.sv
// rtl/mac_matrix_driver.sv - 5x5 signed int8 matrix-product sequencer around one mac8bc2 unit
// Optional feature macro: MAC_OVF_MAP_EN (adds per-element overflow map output ovf_map)
module mac_matrix_driver #(
    parameter int DIM            = 5,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [8*DIM*DIM-1:0]      mat_a,
    input  logic [8*DIM*DIM-1:0]      mat_b,
    output logic [8*DIM*DIM-1:0]      mat_c,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      error,
    output logic [8*DIM-1:0]          mac_inA,
    output logic [8*DIM-1:0]          mac_inB,
    output logic                      mac_en,
    input  logic [7:0]                mac_result,
    input  logic                      mac_overflow,
    input  logic                      mac_done
`ifdef MAC_OVF_MAP_EN
    ,
    output logic [DIM*DIM-1:0]        ovf_map
`endif
);

    localparam int IW = 3;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    generate
        if (DIM != 5) begin : g_dim_check
            $error("mac_matrix_driver: DIM must be 5 to match the 5-lane MAC");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [8*DIM*DIM-1:0]   a_buf;
    logic [8*DIM*DIM-1:0]   b_buf;
    logic [8*DIM*DIM-1:0]   c_buf;
    logic [IW-1:0]          row_idx;
    logic [IW-1:0]          col_idx;
    logic [TW-1:0]          timer;

    logic                   accept;
    logic                   capture;
    logic                   tmo_hit;
    logic                   advance;
    logic                   last_elem;
    logic                   tmo;
    int                     cur_elem;

    assign mat_c     = c_buf;
    assign busy      = (state == S_SYNC) || (state == S_ISSUE) || (state == S_DRAIN);
    assign done      = (state == S_FINISH);
    assign mac_en    = (state == S_ISSUE);
    assign last_elem = (row_idx == IW'(DIM - 1)) && (col_idx == IW'(DIM - 1));
    assign tmo       = (timer == TW'(TIMEOUT_CYCLES));
    assign cur_elem  = DIM * int'(row_idx) + int'(col_idx);

    // Lane k carries A(i,k) and B(k,j) from the latched copies.
    always_comb begin
        mac_inA = '0;
        mac_inB = '0;
        for (int k = 0; k < DIM; k++) begin
            mac_inA[8*k +: 8] = a_buf[8*(DIM*int'(row_idx) + k) +: 8];
            mac_inB[8*k +: 8] = b_buf[8*(DIM*k + int'(col_idx)) +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        tmo_hit    = 1'b0;
        advance    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (tmo) begin
                    tmo_hit    = 1'b1;
                    state_next = S_FINISH;
                end else if (!mac_done) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mac_done) begin
                    capture    = 1'b1;
                    state_next = S_DRAIN;
                end else if (tmo) begin
                    tmo_hit    = 1'b1;
                    state_next = S_FINISH;
                end
            end
            S_DRAIN: begin
                if (!mac_done) begin
                    advance    = 1'b1;
                    state_next = last_elem ? S_FINISH : S_ISSUE;
                end else if (tmo) begin
                    tmo_hit    = 1'b1;
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_buf    <= '0;
            b_buf    <= '0;
            c_buf    <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
            timer    <= '0;
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            // Per-state dwell counter, saturating at the timeout value.
            if (state_next != state) begin
                timer <= '0;
            end else if (!tmo) begin
                timer <= timer + 1'b1;
            end

            if (accept) begin
                a_buf    <= mat_a;
                b_buf    <= mat_b;
                c_buf    <= '0;
                row_idx  <= '0;
                col_idx  <= '0;
                overflow <= 1'b0;
                error    <= 1'b0;
            end

            if (state == S_ISSUE) begin
                overflow <= overflow | mac_overflow;
            end

            if (capture) begin
                c_buf[8*cur_elem +: 8] <= mac_result;
            end

            if (tmo_hit) begin
                c_buf[8*cur_elem +: 8] <= 8'h00;
                error                  <= 1'b1;
            end

            if (advance) begin
                if (last_elem) begin
                    row_idx <= '0;
                    col_idx <= '0;
                end else if (col_idx == IW'(DIM - 1)) begin
                    col_idx <= '0;
                    row_idx <= row_idx + 1'b1;
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end
        end
    end

`ifdef MAC_OVF_MAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_map <= '0;
        end else if (accept) begin
            ovf_map <= '0;
        end else if (state == S_ISSUE) begin
            ovf_map[cur_elem] <= ovf_map[cur_elem] | mac_overflow;
        end
    end
`endif

endmodule

// File: tb/tb_mac_matrix_driver.sv
// tb/tb_mac_matrix_driver.sv - scoreboard bench for mac_matrix_driver with a behavioural mac8bc2 stub
module tb_mac_matrix_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [199:0] mat_a;
    logic [199:0] mat_b;
    logic [199:0] mat_c;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         error;
    logic [39:0]  mac_inA;
    logic [39:0]  mac_inB;
    logic         mac_en;
    logic [7:0]   mac_result;
    logic         mac_overflow;
    logic         mac_done;
`ifdef MAC_OVF_MAP_EN
    logic [24:0]  ovf_map;
`endif

    mac_matrix_driver dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mat_a        (mat_a),
        .mat_b        (mat_b),
        .mat_c        (mat_c),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .error        (error),
        .mac_inA      (mac_inA),
        .mac_inB      (mac_inB),
        .mac_en       (mac_en),
        .mac_result   (mac_result),
        .mac_overflow (mac_overflow),
        .mac_done     (mac_done)
`ifdef MAC_OVF_MAP_EN
        ,
        .ovf_map      (ovf_map)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] c;
        logic         ovf;
        logic         err;
        logic [24:0]  map;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   mac_mode = 0;   // 0 conforming, 1 never done, 2 done stuck high
    int   mac_cnt = 0;
    int   mac_sum;
    bit   prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dot(input logic [39:0] x, input logic [39:0] y);
        int s = 0;
        for (int k = 0; k < 5; k++) begin
            s += int'($signed(x[8*k +: 8])) * int'($signed(y[8*k +: 8]));
        end
        return s;
    endfunction

    // mac8bc2 stub: done rises after 6 enabled edges, drops as soon as enable drops.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mac_en) mac_cnt <= 0;
        else if (mac_cnt < 6) mac_cnt <= mac_cnt + 1;
    end

    always_comb mac_sum = dot(mac_inA, mac_inB);
    assign mac_result   = mac_sum[7:0];
    assign mac_overflow = mac_en && (mac_sum > 127 || mac_sum < -128);
    assign mac_done     = (mac_mode == 2) ? 1'b1 :
                          (mac_mode == 1) ? 1'b0 : (mac_en && mac_cnt == 6);

    task automatic model(input logic [199:0] a, input logic [199:0] b,
                         output logic [199:0] c, output logic ovf, output logic [24:0] map);
        logic [39:0] ra;
        logic [39:0] cb;
        int          s;
        c   = '0;
        ovf = 1'b0;
        map = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                for (int k = 0; k < 5; k++) begin
                    ra[8*k +: 8] = a[8*(5*i + k) +: 8];
                    cb[8*k +: 8] = b[8*(5*k + j) +: 8];
                end
                s = dot(ra, cb);
                c[8*(5*i + j) +: 8] = s[7:0];
                map[5*i + j] = (s > 127 || s < -128);
                ovf = ovf | map[5*i + j];
            end
        end
    endtask

    always @(negedge clk) begin
        if (prev_done) check_eq("done_one_cycle", done, 1'b0);
        prev_done = done;
        if (done) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check_eq("mat_c", mat_c, mon_e.c);
                check_eq("overflow", overflow, mon_e.ovf);
                check_eq("error", error, mon_e.err);
                check_eq("busy_at_done", busy, 1'b0);
                check_eq("done_latency", cyc - t0, mon_e.lat);
`ifdef MAC_OVF_MAP_EN
                check_eq("ovf_map", ovf_map, mon_e.map);
`endif
            end
        end
    end

    task automatic do_run(input logic [199:0] a, input logic [199:0] b,
                          input int mode, input int lat, input bit inject);
        exp_t        e;
        logic [199:0] c;
        logic        ovf;
        logic [24:0] map;
        model(a, b, c, ovf, map);
        e.c = c; e.ovf = ovf; e.map = map; e.err = 1'b0; e.lat = lat;
        if (mode == 1) begin
            e.c = '0; e.ovf = 1'b0; e.map = '0; e.err = 1'b1;
        end
        sb.push_back(e);
        @(negedge clk);
        mac_mode = mode;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        check_eq("busy_after_start", busy, 1'b1);
        if (mode == 2) begin
            repeat (5) @(posedge clk);
            #1 mac_mode = 0;
        end
        if (inject) begin
            repeat (3) @(posedge clk);
            #1 mat_a = ~a;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int n = 0; n < 400 && sb.size() != 0; n++) @(posedge clk);
        if (sb.size() != 0) begin
            check_eq("run_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [199:0] ma, mb;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mat_a = '0;
        mat_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mat_c", mat_c, 200'h0);
        check_eq("rst_flags", {busy, done, overflow, error, mac_en}, 5'b0);
        check_eq("rst_mac_in", {mac_inA, mac_inB}, 80'h0);
        @(negedge clk) rst = 1'b0;

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                ma[8*(5*r + c) +: 8] = (r == c) ? 8'd1 : 8'd0;
                mb[8*(5*r + c) +: 8] = 8'(5*r + c);
            end
        do_run(ma, mb, 0, 201, 1'b0);

        do_run({25{8'd2}}, {25{8'd3}}, 0, 201, 1'b0);

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mb[8*(5*r + c) +: 8] = 8'(c);
        do_run({25{8'hFF}}, mb, 0, 201, 1'b0);

        do_run({25{8'd100}}, {25{8'd2}}, 0, 201, 1'b0);

        for (int n = 0; n < 25; n++) begin
            ma[8*n +: 8] = 8'($urandom_range(0, 255));
            mb[8*n +: 8] = 8'($urandom_range(0, 255));
        end
        do_run(ma, mb, 0, 201, 1'b0);

        do_run({25{8'd2}}, {25{8'd3}}, 1, 17, 1'b1);

        // Reset in the middle of element (2,3) with the MAC's done left high.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                ma[8*(5*r + c) +: 8] = (r == c) ? 8'd1 : 8'd0;
                mb[8*(5*r + c) +: 8] = 8'(5*r + c);
            end
        @(negedge clk);
        mac_mode = 0;
        mat_a = ma;
        mat_b = mb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (108) @(posedge clk);
        #1;
        check_eq("mid_mac_en", mac_en, 1'b1);
        check_eq("mid_mac_inA", mac_inA, 40'h0000010000);
        check_eq("mid_mac_inB", mac_inB, 40'h17120D0803);
        mac_mode = 2;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_mat_c", mat_c, 200'h0);
        check_eq("midrst_flags", {busy, done, overflow, error, mac_en}, 5'b0);
        @(negedge clk) rst = 1'b0;
        do_run(ma, mb, 2, 206, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
